// File: rtl/stream_comparator_if.sv
// Operand/result stream bundle for stream_comparator: valid/ready input pair side
// and valid/ready registered result side.
interface stream_comparator_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             signed_mode;
  logic             out_valid;
  logic             out_ready;
  logic             eq;
  logic             gt;
  logic             lt;

  modport master (
    output in_valid, a, b, signed_mode, out_ready,
    input  in_ready, out_valid, eq, gt, lt
  );

  modport slave (
    input  in_valid, a, b, signed_mode, out_ready,
    output in_ready, out_valid, eq, gt, lt
  );
endinterface

// File: rtl/stream_comparator.sv
// Single-register valid/ready comparator producing one-hot eq/gt/lt per operand pair.
// Define CMP_EVENT_COUNTERS_EN to build the saturating per-flag delivery counters.
module stream_comparator #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  stream_comparator_if.slave  bus,
  input  logic                clr_cnt,
  output logic [CNT_W-1:0]    cnt_eq,
  output logic [CNT_W-1:0]    cnt_gt,
  output logic [CNT_W-1:0]    cnt_lt
);

  // Signed compare is an unsigned compare with both sign bits inverted.
  // Returns {gt, lt, eq}; works for WIDTH = 1 where a set bit means -1.
  function automatic logic [2:0] compare_f(
    input logic [WIDTH-1:0] op_a,
    input logic [WIDTH-1:0] op_b,
    input logic             is_signed
  );
    logic [WIDTH-1:0] ka;
    logic [WIDTH-1:0] kb;
    ka = op_a;
    kb = op_b;
    ka[WIDTH-1] = op_a[WIDTH-1] ^ is_signed;
    kb[WIDTH-1] = op_b[WIDTH-1] ^ is_signed;
    return {(ka > kb), (ka < kb), (ka == kb)};
  endfunction

  logic       out_valid_r;
  logic       eq_r;
  logic       gt_r;
  logic       lt_r;
  logic       in_ready_s;
  logic       in_hs_s;
  logic       out_hs_s;
  logic [2:0] cmp_s;

  // Handshake qualifiers and the combinational compare of the offered pair
  always_comb begin
    in_ready_s = 1'b0;
    in_hs_s    = 1'b0;
    out_hs_s   = 1'b0;
    cmp_s      = 3'b000;
    in_ready_s = (!out_valid_r) || bus.out_ready;
    in_hs_s    = bus.in_valid && in_ready_s;
    out_hs_s   = out_valid_r && bus.out_ready;
    cmp_s      = compare_f(bus.a, bus.b, bus.signed_mode);
  end

  // Result register: load on input handshake, drop valid on a lone output handshake
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      eq_r        <= 1'b0;
      gt_r        <= 1'b0;
      lt_r        <= 1'b0;
    end else if (in_hs_s) begin
      out_valid_r <= 1'b1;
      gt_r        <= cmp_s[2];
      lt_r        <= cmp_s[1];
      eq_r        <= cmp_s[0];
    end else if (out_hs_s) begin
      out_valid_r <= 1'b0;
      eq_r        <= eq_r;
      gt_r        <= gt_r;
      lt_r        <= lt_r;
    end else begin
      out_valid_r <= out_valid_r;
      eq_r        <= eq_r;
      gt_r        <= gt_r;
      lt_r        <= lt_r;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.eq        = eq_r;
  assign bus.gt        = gt_r;
  assign bus.lt        = lt_r;

`ifdef CMP_EVENT_COUNTERS_EN
  function automatic logic [CNT_W-1:0] sat_inc_f(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + CNT_W'(1'b1);
    end
  endfunction

  logic [CNT_W-1:0] cnt_eq_r;
  logic [CNT_W-1:0] cnt_gt_r;
  logic [CNT_W-1:0] cnt_lt_r;
  logic [CNT_W-1:0] cnt_eq_nxt_s;
  logic [CNT_W-1:0] cnt_gt_nxt_s;
  logic [CNT_W-1:0] cnt_lt_nxt_s;

  // Counter next state: clear wins over a coincident delivery
  always_comb begin
    cnt_eq_nxt_s = cnt_eq_r;
    cnt_gt_nxt_s = cnt_gt_r;
    cnt_lt_nxt_s = cnt_lt_r;
    if (clr_cnt) begin
      cnt_eq_nxt_s = {CNT_W{1'b0}};
      cnt_gt_nxt_s = {CNT_W{1'b0}};
      cnt_lt_nxt_s = {CNT_W{1'b0}};
    end else if (out_hs_s) begin
      cnt_eq_nxt_s = eq_r ? sat_inc_f(cnt_eq_r) : cnt_eq_r;
      cnt_gt_nxt_s = gt_r ? sat_inc_f(cnt_gt_r) : cnt_gt_r;
      cnt_lt_nxt_s = lt_r ? sat_inc_f(cnt_lt_r) : cnt_lt_r;
    end else begin
      cnt_eq_nxt_s = cnt_eq_r;
      cnt_gt_nxt_s = cnt_gt_r;
      cnt_lt_nxt_s = cnt_lt_r;
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_eq_r <= {CNT_W{1'b0}};
      cnt_gt_r <= {CNT_W{1'b0}};
      cnt_lt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_eq_r <= cnt_eq_nxt_s;
      cnt_gt_r <= cnt_gt_nxt_s;
      cnt_lt_r <= cnt_lt_nxt_s;
    end
  end

  assign cnt_eq = cnt_eq_r;
  assign cnt_gt = cnt_gt_r;
  assign cnt_lt = cnt_lt_r;
`else
  logic unused_clr_cnt_s;
  assign unused_clr_cnt_s = clr_cnt;
  assign cnt_eq = {CNT_W{1'b0}};
  assign cnt_gt = {CNT_W{1'b0}};
  assign cnt_lt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_stream_comparator.sv
// Randomized self-checking bench for stream_comparator against an arithmetic reference model.
module tb_stream_comparator;
  localparam int W  = 8;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;
`ifdef CMP_EVENT_COUNTERS_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          clr_cnt = 1'b0;
  logic [CW-1:0] cnt_eq, cnt_gt, cnt_lt;

  stream_comparator_if #(.WIDTH(W)) bus ();

  stream_comparator #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .clr_cnt(clr_cnt),
    .cnt_eq(cnt_eq), .cnt_gt(cnt_gt), .cnt_lt(cnt_lt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit m_valid = 1'b0;
  bit m_eq = 1'b0, m_gt = 1'b0, m_lt = 1'b0;
  int m_cnt[3] = '{0, 0, 0};   // eq, gt, lt
  int n_delivered = 0;

  function automatic int to_int(input logic [W-1:0] v, input bit sm);
    int r;
    r = int'(v);
    if (sm && r >= (1 << (W - 1))) r = r - (1 << W);
    return r;
  endfunction

  function automatic int exp_cnt(input int idx);
    return CNT_EN ? m_cnt[idx] : 0;
  endfunction

  task automatic drive(input bit iv, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input bit sm, input bit ordy, input bit clr);
    bus.in_valid = iv; bus.a = av; bus.b = bv;
    bus.signed_mode = sm; bus.out_ready = ordy; clr_cnt = clr;
  endtask

  // advance one clock and update the model from what was offered before the edge
  task automatic tick();
    bit ohs, ihs;
    int sa, sb;
    ohs = m_valid && bus.out_ready;
    ihs = bus.in_valid && (!m_valid || bus.out_ready);
    sa  = to_int(bus.a, bus.signed_mode);
    sb  = to_int(bus.b, bus.signed_mode);
    @(posedge clk); #1;
    if (!rst_n) begin
      m_valid = 1'b0; m_eq = 1'b0; m_gt = 1'b0; m_lt = 1'b0;
      m_cnt = '{0, 0, 0};
    end else begin
      if (ohs) n_delivered++;
      if (clr_cnt) m_cnt = '{0, 0, 0};
      else if (ohs) begin
        if (m_eq && m_cnt[0] < CMAX) m_cnt[0]++;
        if (m_gt && m_cnt[1] < CMAX) m_cnt[1]++;
        if (m_lt && m_cnt[2] < CMAX) m_cnt[2]++;
      end
      if (ihs) begin
        m_valid = 1'b1; m_eq = (sa == sb); m_gt = (sa > sb); m_lt = (sa < sb);
      end else if (ohs) m_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 8'h12, 8'h34, 1'b0, 1'b1, 1'b0);
    tick(); tick();
    checks++;
    if (bus.out_valid !== 1'b0 || {bus.eq, bus.gt, bus.lt} !== 3'b000) begin
      errors++; $display("FAIL reset_out: got v=%b flags=%b%b%b exp 0 000", bus.out_valid, bus.eq, bus.gt, bus.lt);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b exp 1", bus.in_ready);
    end
    checks++;
    if ({cnt_eq, cnt_gt, cnt_lt} !== {3*CW{1'b0}}) begin
      errors++; $display("FAIL reset_cnt: got %h/%h/%h exp 0", cnt_eq, cnt_gt, cnt_lt);
    end
    rst_n = 1'b1;
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    tick();
  endtask

  task automatic test_unsigned();
    logic [W-1:0] av[3] = '{8'h05, 8'hF0, 8'h02};
    logic [W-1:0] bv[3] = '{8'h05, 8'h0F, 8'h07};
    bit [2:0]     ex[3] = '{3'b100, 3'b010, 3'b001};   // {eq,gt,lt}
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, av[i], bv[i], 1'b0, 1'b1, 1'b0);
      tick();
      checks++;
      if (bus.out_valid !== 1'b1 || {bus.eq, bus.gt, bus.lt} !== ex[i]) begin
        errors++; $display("FAIL unsigned_%0d: got v=%b flags=%b%b%b exp 1 %b", i, bus.out_valid, bus.eq, bus.gt, bus.lt, ex[i]);
      end
      checks++;
      if (cnt_eq !== CW'(exp_cnt(0)) || cnt_gt !== CW'(exp_cnt(1)) || cnt_lt !== CW'(exp_cnt(2))) begin
        errors++; $display("FAIL unsigned_cnt_%0d: got %0d/%0d/%0d exp %0d/%0d/%0d", i, cnt_eq, cnt_gt, cnt_lt, exp_cnt(0), exp_cnt(1), exp_cnt(2));
      end
    end
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    tick();
  endtask

  task automatic test_signed();
    bit [2:0] ex[2] = '{3'b001, 3'b010};
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 8'hF0, 8'h0F, (i == 0), 1'b1, 1'b0);
      tick();
      checks++;
      if (bus.out_valid !== 1'b1 || {bus.eq, bus.gt, bus.lt} !== ex[i]) begin
        errors++; $display("FAIL signed_%0d: got v=%b flags=%b%b%b exp 1 %b", i, bus.out_valid, bus.eq, bus.gt, bus.lt, ex[i]);
      end
    end
    drive(1'b1, 8'h80, 8'h7F, 1'b1, 1'b1, 1'b0);   // most negative vs most positive
    tick();
    checks++;
    if ({bus.eq, bus.gt, bus.lt} !== 3'b001) begin
      errors++; $display("FAIL signed_extreme: got %b%b%b exp 001", bus.eq, bus.gt, bus.lt);
    end
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    tick();
  endtask

  task automatic test_backpressure();
    bit [2:0] held;
    drive(1'b1, 8'h40, 8'h20, 1'b0, 1'b0, 1'b0);   // gt pending
    tick();
    held = {bus.eq, bus.gt, bus.lt};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0);
      #1;
      checks++;
      if (bus.in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_in_ready_%0d: got %b exp 0", i, bus.in_ready);
      end
      tick();
      checks++;
      if (bus.out_valid !== 1'b1 || {bus.eq, bus.gt, bus.lt} !== 3'b010 || held !== 3'b010) begin
        errors++; $display("FAIL bp_hold_%0d: got v=%b flags=%b%b%b exp 1 010", i, bus.out_valid, bus.eq, bus.gt, bus.lt);
      end
    end
    drive(1'b1, 8'h01, 8'h02, 1'b0, 1'b1, 1'b0);   // deliver + load lt
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release_ready: got %b exp 1", bus.in_ready);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b1 || {bus.eq, bus.gt, bus.lt} !== 3'b001) begin
      errors++; $display("FAIL bp_b2b: got v=%b flags=%b%b%b exp 1 001", bus.out_valid, bus.eq, bus.gt, bus.lt);
    end
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    tick();
    checks++;
    if (bus.out_valid !== 1'b0 || {bus.eq, bus.gt, bus.lt} !== 3'b001) begin
      errors++; $display("FAIL bp_drain: got v=%b flags=%b%b%b exp 0 001", bus.out_valid, bus.eq, bus.gt, bus.lt);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] av, bv;
    for (int i = 0; i < 400; i++) begin
      av = W'($urandom);
      bv = ($urandom_range(0, 3) == 0) ? av : W'($urandom);
      drive(($urandom_range(0, 3) != 0), av, bv, 1'($urandom), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 40) == 0));
      #1;
      checks++;
      if (bus.in_ready !== (!m_valid || bus.out_ready)) begin
        errors++; $display("FAIL rand_in_ready_%0d: got %b exp %b", i, bus.in_ready, (!m_valid || bus.out_ready));
      end
      tick();
      checks++;
      if (bus.out_valid !== m_valid || {bus.eq, bus.gt, bus.lt} !== {m_eq, m_gt, m_lt}) begin
        errors++; $display("FAIL rand_out_%0d: got v=%b flags=%b%b%b exp %b %b%b%b", i, bus.out_valid, bus.eq, bus.gt, bus.lt, m_valid, m_eq, m_gt, m_lt);
      end
      checks++;
      if (cnt_eq !== CW'(exp_cnt(0)) || cnt_gt !== CW'(exp_cnt(1)) || cnt_lt !== CW'(exp_cnt(2))) begin
        errors++; $display("FAIL rand_cnt_%0d: got %0d/%0d/%0d exp %0d/%0d/%0d", i, cnt_eq, cnt_gt, cnt_lt, exp_cnt(0), exp_cnt(1), exp_cnt(2));
      end
    end
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    tick();
  endtask

  task automatic test_saturation();
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
    tick();
    for (int i = 0; i < 21; i++) begin
      drive(1'b1, 8'h90, W'($urandom_range(0, 143)), 1'b0, 1'b1, 1'b0);
      tick();
    end
    checks++;
    if (cnt_gt !== CW'(exp_cnt(1)) || (CNT_EN && m_cnt[1] != CMAX)) begin
      errors++; $display("FAIL sat_gt: got %0d exp %0d (model %0d)", cnt_gt, exp_cnt(1), m_cnt[1]);
    end
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);   // gt delivery coincides with clear
    tick();
    checks++;
    if (cnt_gt !== 4'h0 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL sat_clr: got cnt=%0d v=%b exp 0 0", cnt_gt, bus.out_valid);
    end
    clr_cnt = 1'b0;
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'h33, 8'h33, 1'b0, 1'b1, 1'b0);
      tick();
    end
    drive(1'b1, 8'h11, 8'h22, 1'b0, 1'b0, 1'b0);
    tick();   // pending undelivered result
    rst_n = 1'b0;
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    checks++;
    if (bus.out_valid !== 1'b0 || {cnt_eq, cnt_gt, cnt_lt} !== {3*CW{1'b0}}) begin
      errors++; $display("FAIL midrst: got v=%b cnt=%0d/%0d/%0d exp 0 0/0/0", bus.out_valid, cnt_eq, cnt_gt, cnt_lt);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
      tick();
      checks++;
      if (bus.out_valid !== 1'b0 || {cnt_eq, cnt_gt, cnt_lt} !== {3*CW{1'b0}}) begin
        errors++; $display("FAIL midrst_after_%0d: got v=%b cnt=%0d/%0d/%0d exp 0 0/0/0", i, bus.out_valid, cnt_eq, cnt_gt, cnt_lt);
      end
    end
  endtask

  initial begin
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    #1;
    test_reset();
    test_unsigned();
    test_signed();
    test_backpressure();
    test_random();
    test_saturation();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
